// File: rtl/serial_adder_x16_pkg.sv
// rtl/serial_adder_x16_pkg.sv - shared types and constants for the d16i ALU serial add path
// Purpose: FSM state enum, default word width and counter-width helper.
// Ports:   none (package).
package d16i_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } serial_add_state_t;

    localparam int D16I_WORD_W = 16;

    // Bit counter must index 0 .. width-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_x16_if.sv
// rtl/serial_adder_x16_if.sv - operand/result handshake bundle for serial_adder_x16
// Purpose: groups the operand (in_*) and result (out_*) handshakes.
// Ports:   master = operand producer / result consumer, slave = adder.
//          in_valid, in_ready, a, b, cin, out_valid, out_ready, z, cout
//          ovf is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_x16_if
    import d16i_alu_pkg::*;
#(
    parameter int WIDTH = D16I_WORD_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, z, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, z, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, z, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, z, cout
    );
`endif
endinterface

// File: rtl/serial_adder_x16_full_adder.sv
// rtl/serial_adder_x16_full_adder.sv - 1-bit combinational full adder cell
// Purpose: per-bit cell reused every BUSY cycle by serial_adder_x16.
// Ports:   i_a, i_b, i_cin -> o_z (sum), o_cout (carry-out)
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_z,
    output logic o_cout
);
    assign o_z    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder_x16.sv
// rtl/serial_adder_x16.sv - bit-serial WIDTH-bit adder, z = a + b + cin with carry-out
// Purpose: one full_adder evaluated over WIDTH cycles; IDLE -> BUSY -> DONE FSM.
// Ports:   clk, rst_n (async, active-low), sa (serial_adder_x16_if.slave).
// Config:  SERIAL_ADDER_OVF_EN adds sa.ovf (two's-complement signed overflow).
module serial_adder_x16
    import d16i_alu_pkg::*;
#(
    parameter int WIDTH = D16I_WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_x16_if.slave  sa
);
    localparam int              CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    serial_add_state_t r_state;
    serial_add_state_t w_next;

    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    // Partial sum; holds the WIDTH-1 earlier bits, the last bit joins it
    // directly when the result is published.
    logic [WIDTH-2:0] r_sum;
    logic [WIDTH-1:0] r_z;
    logic             r_cout;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_cmsb;
`endif

    logic w_fa_z;
    logic w_fa_cout;
    logic w_accept;
    logic w_last;

    full_adder u_fa (
        .i_a    (r_op_a[0]),
        .i_b    (r_op_b[0]),
        .i_cin  (r_carry),
        .o_z    (w_fa_z),
        .o_cout (w_fa_cout)
    );

    assign w_accept = (r_state == IDLE) && sa.in_valid;
    assign w_last   = (r_state == BUSY) && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sa.in_valid)  w_next = BUSY;
            BUSY:    if (w_last)       w_next = DONE;
            DONE:    if (sa.out_ready) w_next = IDLE;
            default:                   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_z     <= '0;
            r_cout  <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            r_cmsb  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_op_a  <= sa.a;
            r_op_b  <= sa.b;
            r_carry <= sa.cin;
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_op_a  <= r_op_a >> 1;
            r_op_b  <= r_op_b >> 1;
            r_sum   <= {w_fa_z, r_sum[WIDTH-2:1]};
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Publish only on the final bit so z/cout stay at the previous
            // result throughout the next operation's BUSY phase.
            if (w_last) begin
                r_z    <= {w_fa_z, r_sum};
                r_cout <= w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                r_cmsb <= r_carry;
`endif
            end
        end
    end

    assign sa.in_ready  = (r_state == IDLE);
    assign sa.out_valid = (r_state == DONE);
    assign sa.z         = r_z;
    assign sa.cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign sa.ovf       = r_cmsb ^ r_cout;
`endif

endmodule

// File: tb/tb_serial_adder_x16.sv
// tb/tb_serial_adder_x16.sv - randomized self-checking bench for serial_adder_x16
module tb_serial_adder_x16;
    import d16i_alu_pkg::*;

    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_adder_x16_if #(.WIDTH(W)) sa ();

    serial_adder_x16 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sa    (sa)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] prev_z    = '0;
    logic         prev_cout = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int unsigned s;
        s = int'(x) + int'(y) + int'(c);
        return s[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 32767) || (s < -32768);
    endfunction

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input int hold, input bit inject);
        logic [W:0] exp;
        int         lat;
        int         guard;
        exp = ref_sum(ta, tb, tc);

        guard = 0;
        while (sa.in_ready !== 1'b1 && guard < 64) begin
            @(posedge clk); #1; guard++;
        end
        check("in_ready_before_accept", sa.in_ready, 1'b1);

        sa.in_valid = 1'b1;
        sa.a = ta;
        sa.b = tb;
        sa.cin = tc;
        @(posedge clk); #1;
        sa.in_valid = 1'b0;
        sa.a = W'($urandom);
        sa.b = W'($urandom);
        sa.cin = 1'($urandom);

        lat = 0;
        while (sa.out_valid !== 1'b1 && lat < 64) begin
            if (inject && lat == 4) begin
                sa.in_valid = 1'b1;
                sa.a = 16'hAAAA;
                sa.b = 16'h5555;
                sa.cin = 1'b1;
            end
            if (lat == 8) begin
                check("busy_in_ready", sa.in_ready, 1'b0);
                check("busy_z_hold", sa.z, prev_z);
                check("busy_cout_hold", sa.cout, prev_cout);
            end
            @(posedge clk); #1;
            lat++;
        end
        sa.in_valid = 1'b0;
        check("latency", lat, W);
        check("z", sa.z, exp[W-1:0]);
        check("cout", sa.cout, exp[W]);
        check("done_in_ready", sa.in_ready, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", sa.ovf, ref_ovf(ta, tb, tc));
`endif

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", sa.out_valid, 1'b1);
            check("bp_in_ready", sa.in_ready, 1'b0);
            check("bp_z", sa.z, exp[W-1:0]);
            check("bp_cout", sa.cout, exp[W]);
        end

        sa.out_ready = 1'b1;
        @(posedge clk); #1;
        sa.out_ready = 1'b0;
        check("post_out_valid", sa.out_valid, 1'b0);
        check("post_in_ready", sa.in_ready, 1'b1);
        check("post_z_hold", sa.z, exp[W-1:0]);
        check("post_cout_hold", sa.cout, exp[W]);

        prev_z    = exp[W-1:0];
        prev_cout = exp[W];
    endtask

    initial begin
        sa.in_valid  = 1'b0;
        sa.a         = '0;
        sa.b         = '0;
        sa.cin       = 1'b0;
        sa.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", sa.out_valid, 1'b0);
        check("rst_z", sa.z, 16'h0000);
        check("rst_cout", sa.cout, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", sa.in_ready, 1'b1);

        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 5, 1'b0);
        run_op(16'h0F0F, 16'h1111, 1'b0, 0, 1'b1);

        for (int k = 0; k < 40; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        // Mid-operation reset: previous z is known non-zero (0x5556).
        run_op(16'h1234, 16'h4321, 1'b1, 0, 1'b0);
        sa.in_valid = 1'b1;
        sa.a = 16'hFFFF;
        sa.b = 16'h0001;
        sa.cin = 1'b0;
        @(posedge clk); #1;
        sa.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", sa.out_valid, 1'b0);
        check("abort_z", sa.z, 16'h0000);
        check("abort_cout", sa.cout, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", sa.in_ready, 1'b1);
        check("abort_no_valid", sa.out_valid, 1'b0);
        prev_z    = '0;
        prev_cout = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_x16.md
Name: serial_adder_x16

Overview:
- Bit-serial 16-bit adder; the additive counterpart of the datapath's ripple subtractor.
- Reuses a single 1-bit full adder over WIDTH cycles instead of a 16-stage ripple chain.
- Accepts operands through a valid/ready handshake and returns z = a + b + cin with carry-out.
- Sits in the d16i ALU as the low-area ADD path; the ALU sequencer stalls on its ready/valid.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands a, b, cin valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  augend
- b  input  WIDTH  addend
- cin  input  1  carry-in
- out_valid  output  1  z/cout valid
- out_ready  input  1  consumer accepts result
- z  output  WIDTH  sum, low WIDTH bits
- cout  output  1  carry-out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; out_valid = 0; z = 0; cout = 0; bit counter = 0; carry flop = 0.
  - in_ready = 1 once rst_n is deasserted.
- States and transitions:
  - IDLE -> BUSY on in_valid & in_ready.
  - BUSY -> DONE after WIDTH BUSY cycles.
  - DONE -> IDLE on out_valid & out_ready.
- in_ready is a pure decode of state == IDLE. There is no overlap between operations.
- Accept edge:
  - Latch a and b into operand shift registers; carry flop <= cin; counter <= 0.
  - Inputs need not be held after the accept edge.
- Each BUSY cycle (one full_adder evaluation on op_a[0], op_b[0], carry):
  - Sum bit is shifted into the MSB of the result register, which shifts right.
  - Both operand registers shift right by one.
  - Carry flop <= carry-out.
  - counter increments.
  - On the BUSY cycle with counter == WIDTH-1, the next state is DONE.
- Latency:
  - out_valid rises WIDTH cycles after the accept edge (16 for the default WIDTH).
  - Throughput is one result per WIDTH+2 cycles or more.
- DONE outputs:
  - z = result register; cout = final carry flop.
  - Both are held stable while out_valid is high and out_ready is low (unbounded back-pressure).
- After DONE -> IDLE:
  - out_valid = 0 on the next edge.
  - z and cout keep their last values until the next DONE.
- in_valid while BUSY or DONE is ignored. No operand is captured and no error is raised.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a + b + cin. Boundary cases:
  - 0xFFFF + 0x0000 + 1 -> z = 0x0000, cout = 1.
  - 0 + 0 + 0 -> z = 0x0000, cout = 0.
- Reset asserted mid-operation aborts immediately: no out_valid, the partial result is discarded, and the outputs take their reset values.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit).
  - A flop captures the carry into the MSB on the last BUSY cycle.
  - ovf = that captured carry XOR cout, i.e. two's-complement signed overflow.
  - ovf is valid and held with out_valid; its reset value is 0.
- Undefined: no ovf port and no extra flop; behaviour is otherwise identical.

Decomposition:
- Package d16i_alu_pkg holds:
  - Enum serial_add_state_t {IDLE, BUSY, DONE}.
  - Localparam D16I_WORD_W = 16, used as the WIDTH default.
  - Counter width function $clog2(WIDTH).
- One sub-module is natural: full_adder (a, b, cin -> z, cout), purely combinational, instantiated once as the per-bit cell.

Test Plan:
- a=0x1234, b=0x4321, cin=1 -> after 16 cycles out_valid=1, z=0x5556, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> z=0x0000, cout=1; with SERIAL_ADDER_OVF_EN, ovf=0.
- a=0x7FFF, b=0x0001, cin=0 -> z=0x8000, cout=0; with SERIAL_ADDER_OVF_EN, ovf=1.
- Back-pressure: hold out_ready=0 for 5 cycles after out_valid -> z and cout stable, in_ready=0 throughout; out_ready=1 -> next cycle out_valid=0, in_ready=1.
- Drive in_valid=1 with a=0xAAAA during BUSY -> ignored; the original result is delivered unchanged.
- Pulse rst_n low 8 cycles after accept -> out_valid=0, z=0, cout=0 immediately. After release, in_ready=1, and a fresh 0x0001+0x0001 gives z=0x0002.
